ahb_ri5cy_master: RTL

//  Initiator end of the AHB-Lite fabric: converts a RI5CY-style req/gnt/rvalid data port into

---
 rtl/ahb_ri5cy_master.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ahb_ri5cy_master.sv
// ahb_ri5cy_master: RI5CY req/gnt/rvalid data port to AHB-Lite SINGLE-transfer initiator.
// Define AHB_MST_RSP_REG_EN to register rvalid_o/err_o/rdata_o (one extra cycle of latency).
module ahb_ri5cy_master #(
  parameter int         AHB_ADDR_WIDTH = 32,
  parameter int         AHB_DATA_WIDTH = 32,
  parameter logic [3:0] HPROT_VALUE    = 4'b0011
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic [AHB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [3:0]                be_i,
  input  logic [AHB_DATA_WIDTH-1:0] wdata_i,
  output logic                      rvalid_o,
  output logic [AHB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic [AHB_ADDR_WIDTH-1:0] haddr_o,
  output logic                      hwrite_o,
  output logic [2:0]                hsize_o,
  output logic [2:0]                hburst_o,
  output logic [3:0]                hprot_o,
  output logic [1:0]                htrans_o,
  output logic                      hmastlock_o,
  output logic [AHB_DATA_WIDTH-1:0] hwdata_o,
  input  logic [AHB_DATA_WIDTH-1:0] hrdata_i,
  input  logic                      hready_i,
  input  logic                      hresp_i
);

  typedef enum logic [1:0] {HTRANS_IDLE = 2'b00, HTRANS_NONSEQ = 2'b10} htrans_e;
  typedef enum logic [2:0] {HSIZE_BYTE = 3'b000, HSIZE_HALF = 3'b001, HSIZE_WORD = 3'b010} hsize_e;

  logic                      dphase_q, dphase_d;
  logic                      dp_write_q, dp_write_d;
  logic [AHB_DATA_WIDTH-1:0] hwdata_q, hwdata_d;
  logic                      abort;
  logic                      done;
  hsize_e                    size;
  logic [1:0]                offset;

  // abort covers both ERROR cycles: the first withholds the grant, the second completes.
  assign abort = dphase_q & hresp_i;
  assign done  = dphase_q & hready_i;

  assign gnt_o       = rstn & req_i & hready_i & ~abort;
  assign htrans_o    = (rstn & req_i & ~abort) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hwrite_o    = we_i;
  assign hsize_o     = size;
  assign haddr_o     = {addr_i[AHB_ADDR_WIDTH-1:2], offset};
  assign hburst_o    = 3'b000;
  assign hprot_o     = HPROT_VALUE;
  assign hmastlock_o = 1'b0;
  assign hwdata_o    = hwdata_q;

  // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    size   = HSIZE_WORD;
    offset = 2'b00;
    case (be_i)
      4'b0011: size = HSIZE_HALF;
      4'b1100: begin size = HSIZE_HALF; offset = 2'b10; end
      4'b0001: size = HSIZE_BYTE;
      4'b0010: begin size = HSIZE_BYTE; offset = 2'b01; end
      4'b0100: begin size = HSIZE_BYTE; offset = 2'b10; end
      4'b1000: begin size = HSIZE_BYTE; offset = 2'b11; end
      default: ;
    endcase
  end

  always_comb begin
    dphase_d   = dphase_q;
    dp_write_d = dp_write_q;
    hwdata_d   = hwdata_q;
    if (done) dphase_d = 1'b0;
    // A grant in the completion cycle overrides the clear: back-to-back pipelining.
    if (gnt_o) begin
      dphase_d   = 1'b1;
      dp_write_d = we_i;
      hwdata_d   = wdata_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments and clears on the async reset edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dphase_q   <= 1'b0;
      dp_write_q <= 1'b0;
      hwdata_q   <= '0;
    end else begin
      dphase_q   <= dphase_d;
      dp_write_q <= dp_write_d;
      hwdata_q   <= hwdata_d;
    end
  end

`ifdef AHB_MST_RSP_REG_EN
  logic                      rvalid_q, rvalid_d;
  logic                      err_q, err_d;
  logic [AHB_DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    rvalid_d = done;
    err_d    = done & hresp_i;
    rdata_d  = (done & ~dp_write_q) ? hrdata_i : rdata_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, addr_i[1:0]};
`else
  assign rvalid_o = done;
  assign err_o    = done & hresp_i;
  assign rdata_o  = hrdata_i;

  logic unused_ok;
  assign unused_ok = &{1'b0, addr_i[1:0], dp_write_q};
`endif

endmodule
